// File: rtl/game_pkg.sv
// Shared game constants and the camera sequencer state encoding.
package game_pkg;

  localparam int PHY_WIDTH     = 14;
  localparam int CAM_WIDTH     = 5;
  localparam int BLOCK_WIDTH   = 480;
  localparam int MAX_BLOCK     = 31;
  localparam int CHAR_WIDTH_Y  = 32;
  localparam int SETTLE_FRAMES = 2;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    UPDATE,
    HOLD
  } cam_state_t;

endpackage

// File: rtl/camera_scroll_ctrl.sv
// Frame-synchronous camera sequencer: samples the character once per frame at
// vblank start and steps the camera block index by one when the character
// centre leaves the visible block. Outputs only change inside vblank.
module camera_scroll_ctrl #(
  parameter int PHY_WIDTH     = game_pkg::PHY_WIDTH,
  parameter int CAM_WIDTH     = game_pkg::CAM_WIDTH,
  parameter int BLOCK_WIDTH   = game_pkg::BLOCK_WIDTH,
  parameter int MAX_BLOCK     = game_pkg::MAX_BLOCK,
  parameter int CHAR_WIDTH_Y  = game_pkg::CHAR_WIDTH_Y,
  parameter int SETTLE_FRAMES = game_pkg::SETTLE_FRAMES
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 frame_start,
  input  logic [PHY_WIDTH-1:0] char_abs_y,
  input  logic                 force_load,
  input  logic [CAM_WIDTH-1:0] force_block,
  output logic [CAM_WIDTH-1:0] camera_y,
  output logic [PHY_WIDTH-1:0] camera_offset,
  output logic                 scroll_pulse,
  output logic                 scroll_dir,
  output logic                 busy
);
  import game_pkg::*;

  // Centre and bounds carry one extra bit so the compare never wraps.
  localparam int                   CW     = PHY_WIDTH + 1;
  localparam logic [CAM_WIDTH-1:0] MAX_B  = CAM_WIDTH'(MAX_BLOCK);
  localparam logic [PHY_WIDTH-1:0] BLK_P  = PHY_WIDTH'(BLOCK_WIDTH);
  localparam logic [CW-1:0]        BLK_C  = CW'(BLOCK_WIDTH);
  localparam logic [CW-1:0]        HALF_C = CW'(CHAR_WIDTH_Y / 2);
  localparam logic [3:0]           SETTLE = 4'(SETTLE_FRAMES);

  cam_state_t           state_q, state_d;
  logic [CAM_WIDTH-1:0] cam_y_q, cam_y_d;
  logic [PHY_WIDTH-1:0] offset_q, offset_d;
  logic [CW-1:0]        centre_q, centre_d;
  logic                 pend_dir_q, pend_dir_d;
  logic                 pulse_q, pulse_d;
  logic                 dir_q, dir_d;
  logic [3:0]           hold_q, hold_d;

  logic [CAM_WIDTH-1:0] force_blk;
  logic [PHY_WIDTH-1:0] force_off;
  logic [CW-1:0]        lo, hi;

  // Next-state and datapath: force_load overrides the FSM; normal steps use only an adder.
  always_comb begin
    state_d    = state_q;
    cam_y_d    = cam_y_q;
    offset_d   = offset_q;
    centre_d   = centre_q;
    pend_dir_d = pend_dir_q;
    pulse_d    = 1'b0;
    dir_d      = dir_q;
    hold_d     = hold_q;

    force_blk = (force_block > MAX_B) ? MAX_B : force_block;
    force_off = PHY_WIDTH'(force_blk) * BLK_P;
    lo        = {1'b0, offset_q};
    hi        = lo + BLK_C;

    if (force_load) begin
      state_d  = IDLE;
      cam_y_d  = force_blk;
      offset_d = force_off;
      hold_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            centre_d = {1'b0, char_abs_y} + HALF_C;
            state_d  = CHECK;
          end
        end
        CHECK: begin
          if (centre_q < lo && cam_y_q != '0) begin
            pend_dir_d = 1'b0;
            state_d    = UPDATE;
          end else if (centre_q >= hi && cam_y_q < MAX_B) begin
            pend_dir_d = 1'b1;
            state_d    = UPDATE;
          end else begin
            state_d = IDLE;
          end
        end
        UPDATE: begin
          if (pend_dir_q) begin
            cam_y_d  = cam_y_q + CAM_WIDTH'(1);
            offset_d = offset_q + BLK_P;
          end else begin
            cam_y_d  = cam_y_q - CAM_WIDTH'(1);
            offset_d = offset_q - BLK_P;
          end
          pulse_d = 1'b1;
          dir_d   = pend_dir_q;
          hold_d  = SETTLE;
          state_d = HOLD;
        end
        HOLD: begin
          // The frame that drains the counter returns to IDLE without being checked.
          if (frame_start) begin
            if (hold_q <= 4'd1) begin
              hold_d  = '0;
              state_d = IDLE;
            end else begin
              hold_d = hold_q - 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cam_y_q    <= '0;
      offset_q   <= '0;
      centre_q   <= '0;
      pend_dir_q <= 1'b0;
      pulse_q    <= 1'b0;
      dir_q      <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cam_y_q    <= cam_y_d;
      offset_q   <= offset_d;
      centre_q   <= centre_d;
      pend_dir_q <= pend_dir_d;
      pulse_q    <= pulse_d;
      dir_q      <= dir_d;
      hold_q     <= hold_d;
    end
  end

  assign camera_y      = cam_y_q;
  assign camera_offset = offset_q;
  assign scroll_pulse  = pulse_q;
  assign scroll_dir    = dir_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_camera_scroll_ctrl.sv
// Directed bench for camera_scroll_ctrl with hand-computed expectations.
module tb_camera_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [13:0] char_abs_y = '0;
  logic        force_load = 1'b0;
  logic [4:0]  force_block = '0;
  logic [4:0]  camera_y;
  logic [13:0] camera_offset;
  logic        scroll_pulse;
  logic        scroll_dir;
  logic        busy;

  // Wider block-index instance, used to reach out-of-range force values.
  logic        frame_start_w = 1'b0;
  logic [13:0] char_abs_y_w = '0;
  logic        force_load_w = 1'b0;
  logic [5:0]  force_block_w = '0;
  logic [5:0]  camera_y_w;
  logic [13:0] camera_offset_w;
  logic        scroll_pulse_w;
  logic        scroll_dir_w;
  logic        busy_w;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  camera_scroll_ctrl dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .frame_start   (frame_start),
    .char_abs_y    (char_abs_y),
    .force_load    (force_load),
    .force_block   (force_block),
    .camera_y      (camera_y),
    .camera_offset (camera_offset),
    .scroll_pulse  (scroll_pulse),
    .scroll_dir    (scroll_dir),
    .busy          (busy)
  );

  camera_scroll_ctrl #(.CAM_WIDTH(6)) dut_w (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .frame_start   (frame_start_w),
    .char_abs_y    (char_abs_y_w),
    .force_load    (force_load_w),
    .force_block   (force_block_w),
    .camera_y      (camera_y_w),
    .camera_offset (camera_offset_w),
    .scroll_pulse  (scroll_pulse_w),
    .scroll_dir    (scroll_dir_w),
    .busy          (busy_w)
  );

  // Offset must always equal block index times 480.
  always @(negedge clk) begin
    int exp_off;
    if (rst_n) begin
      exp_off = int'(camera_y) * 480;
      checks++;
      if (camera_offset !== 14'(exp_off)) begin
        errors++;
        $display("FAIL invariant_offset: camera_offset=%0d expected=%0d (camera_y=%0d)",
                 camera_offset, exp_off, camera_y);
      end
      if (scroll_pulse) pulse_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Drain a two-frame hold back to IDLE.
  task automatic settle();
    frame(); tick();
    frame(); tick();
  endtask

  task automatic do_force(input logic [4:0] blk);
    force_block = blk;
    force_load  = 1'b1;
    tick();
    force_load  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (camera_y !== 5'd0 || camera_offset !== 14'd0 || busy !== 1'b0 ||
        scroll_pulse !== 1'b0 || scroll_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: y=%0d off=%0d busy=%b pulse=%b dir=%b expected 0/0/0/0/0",
               camera_y, camera_offset, busy, scroll_pulse, scroll_dir);
    end
    // Step down, then reset while holding.
    char_abs_y = 14'd470;
    frame(); tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || camera_y !== 5'd1) begin
      errors++;
      $display("FAIL reset_pre_hold: busy=%b y=%0d expected 1/1", busy, camera_y);
    end
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (camera_y !== 5'd0 || camera_offset !== 14'd0 || busy !== 1'b0 || scroll_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: y=%0d off=%0d busy=%b dir=%b expected 0/0/0/0",
               camera_y, camera_offset, busy, scroll_dir);
    end
  endtask

  task automatic test_down_step();
    char_abs_y = 14'd470;
    frame();  // edge N
    checks++;
    if (camera_y !== 5'd0 || scroll_pulse !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL down_n0: y=%0d pulse=%b busy=%b expected 0/0/1", camera_y, scroll_pulse, busy);
    end
    tick();   // edge N+1
    checks++;
    if (camera_y !== 5'd0 || scroll_pulse !== 1'b0) begin
      errors++;
      $display("FAIL down_n1: y=%0d pulse=%b expected 0/0", camera_y, scroll_pulse);
    end
    tick();   // edge N+2
    checks++;
    if (camera_y !== 5'd1 || camera_offset !== 14'd480 || scroll_pulse !== 1'b1 || scroll_dir !== 1'b1) begin
      errors++;
      $display("FAIL down_n2: y=%0d off=%0d pulse=%b dir=%b expected 1/480/1/1",
               camera_y, camera_offset, scroll_pulse, scroll_dir);
    end
    tick();
    checks++;
    if (scroll_pulse !== 1'b0 || camera_y !== 5'd1) begin
      errors++;
      $display("FAIL down_n3: pulse=%b y=%0d expected 0/1", scroll_pulse, camera_y);
    end
    settle();
    checks++;
    if (busy !== 1'b0 || camera_y !== 5'd1) begin
      errors++;
      $display("FAIL down_settle: busy=%b y=%0d expected 0/1", busy, camera_y);
    end
  endtask

  task automatic test_up_step();
    char_abs_y = 14'd400;
    frame(); tick(); tick();
    checks++;
    if (camera_y !== 5'd0 || camera_offset !== 14'd0 || scroll_pulse !== 1'b1 || scroll_dir !== 1'b0) begin
      errors++;
      $display("FAIL up_step: y=%0d off=%0d pulse=%b dir=%b expected 0/0/1/0",
               camera_y, camera_offset, scroll_pulse, scroll_dir);
    end
    tick();
    settle();
    // Floor clamp: already at block 0, centre 16.
    char_abs_y = 14'd0;
    begin
      int p0;
      p0 = pulse_cnt;
      frame(); tick(); tick(); tick();
      checks++;
      if (camera_y !== 5'd0 || busy !== 1'b0 || pulse_cnt !== p0) begin
        errors++;
        $display("FAIL floor_clamp: y=%0d busy=%b pulses=%0d expected 0/0/%0d",
                 camera_y, busy, pulse_cnt, p0);
      end
    end
  endtask

  task automatic test_multi_fall();
    int p0;
    logic [4:0] exp_y;
    do_force(5'd0);
    char_abs_y = 14'd1500;
    p0 = pulse_cnt;
    for (int f = 0; f < 12; f++) begin
      frame(); tick(); tick(); tick();
      exp_y = (f < 3) ? 5'd1 : (f < 6) ? 5'd2 : 5'd3;
      checks++;
      if (camera_y !== exp_y) begin
        errors++;
        $display("FAIL multi_fall_f%0d: y=%0d expected %0d", f, camera_y, exp_y);
      end
    end
    checks++;
    if (pulse_cnt - p0 !== 3) begin
      errors++;
      $display("FAIL multi_fall_pulses: got %0d expected 3", pulse_cnt - p0);
    end
  endtask

  task automatic test_ceiling();
    int p0;
    do_force(5'd31);
    checks++;
    if (camera_y !== 5'd31 || camera_offset !== 14'd14880 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ceiling_load: y=%0d off=%0d busy=%b expected 31/14880/0",
               camera_y, camera_offset, busy);
    end
    char_abs_y = 14'd16000;
    p0 = pulse_cnt;
    frame(); tick(); tick(); tick();
    checks++;
    if (camera_y !== 5'd31 || camera_offset !== 14'd14880 || pulse_cnt !== p0) begin
      errors++;
      $display("FAIL ceiling_clamp: y=%0d off=%0d pulses=%0d expected 31/14880/%0d",
               camera_y, camera_offset, pulse_cnt, p0);
    end
  endtask

  task automatic test_force_vs_frame();
    int p0;
    char_abs_y  = 14'd1500;
    force_block = 5'd5;
    force_load  = 1'b1;
    frame_start = 1'b1;
    p0 = pulse_cnt;
    tick();
    force_load  = 1'b0;
    frame_start = 1'b0;
    checks++;
    if (camera_y !== 5'd5 || camera_offset !== 14'd2400 || busy !== 1'b0 || scroll_pulse !== 1'b0) begin
      errors++;
      $display("FAIL force_frame: y=%0d off=%0d busy=%b pulse=%b expected 5/2400/0/0",
               camera_y, camera_offset, busy, scroll_pulse);
    end
    tick(); tick();
    checks++;
    if (camera_y !== 5'd5 || busy !== 1'b0 || pulse_cnt !== p0) begin
      errors++;
      $display("FAIL force_frame_after: y=%0d busy=%b pulses=%0d expected 5/0/%0d",
               camera_y, busy, pulse_cnt, p0);
    end
    // Force during CHECK aborts the pending up-step.
    frame();
    do_force(5'd7);
    tick(); tick();
    checks++;
    if (camera_y !== 5'd7 || camera_offset !== 14'd3360 || busy !== 1'b0 || pulse_cnt !== p0) begin
      errors++;
      $display("FAIL force_in_check: y=%0d off=%0d busy=%b pulses=%0d expected 7/3360/0/%0d",
               camera_y, camera_offset, busy, pulse_cnt, p0);
    end
    // Out-of-range force value clamps to the top block.
    force_block_w = 6'd40;
    force_load_w  = 1'b1;
    tick();
    force_load_w  = 1'b0;
    checks++;
    if (camera_y_w !== 6'd31 || camera_offset_w !== 14'd14880 || busy_w !== 1'b0) begin
      errors++;
      $display("FAIL force_clamp: y=%0d off=%0d busy=%b expected 31/14880/0",
               camera_y_w, camera_offset_w, busy_w);
    end
  endtask

  initial begin
    test_reset();
    test_down_step();
    test_up_step();
    test_multi_fall();
    test_ceiling();
    test_force_vs_frame();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
